// File: rtl/run_control_pkg.sv
// Shared types and defaults for the processor run controller.
// No logic: latency and backpressure not applicable.
package run_control_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_HALT_OP = 2;

endpackage

// File: rtl/step_counter.sv
// Loadable down-counter tracking the remaining cycles of a step burst.
// Latency: count updates one clock after load/dec/clear. Backpressure: none.
module step_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_val,
    output logic             one
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign one = (count == CNT_W'(1));

endmodule

// File: rtl/run_control.sv
// Run controller: halt-opcode decode, stepping and cycle counting; drives registered run_en.
// Latency: every output one clock after the causing input. Backpressure: none.
// Optional cycle limit (cycle_limit/limit_hit) enabled by RUN_CONTROL_CYCLE_LIMIT_EN.
module run_control
    import run_control_pkg::*;
#(
    parameter int              OP_W    = 2,
    parameter logic [OP_W-1:0] HALT_OP = OP_W'(DEFAULT_HALT_OP),
    parameter int              CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  instruction_from_jno,
    input  logic             op_valid,
    input  logic             resume,
    input  logic             step_req,
    input  logic [CNT_W-1:0] step_n,
`ifdef RUN_CONTROL_CYCLE_LIMIT_EN
    input  logic [CNT_W-1:0] cycle_limit,
    output logic             limit_hit,
`endif
    output logic             run_en,
    output logic             halted,
    output logic             step_done,
    output logic [CNT_W-1:0] cycle_cnt
);

    state_t state, state_nxt;
    logic   hit, limit_halt, stop;
    logic   ctr_load, ctr_clear, step_one, step_done_nxt;

    // Gating with run_en keeps a stale opcode from re-halting a stopped core.
    assign hit = op_valid & run_en & (instruction_from_jno == HALT_OP);

`ifdef RUN_CONTROL_CYCLE_LIMIT_EN
    assign limit_halt = run_en && (cycle_limit != '0) && (cycle_cnt == cycle_limit - 1'b1);
`else
    assign limit_halt = 1'b0;
`endif

    assign stop = hit | limit_halt;

    always_comb begin
        state_nxt     = state;
        ctr_load      = 1'b0;
        ctr_clear     = 1'b0;
        step_done_nxt = 1'b0;
        case (state)
            RUN: begin
                if (stop) state_nxt = HALTED;
            end
            HALTED: begin
                if (resume) begin
                    state_nxt = RUN;
                end else if (step_req && (step_n != '0)) begin
                    state_nxt = STEP;
                    ctr_load  = 1'b1;
                end
            end
            STEP: begin
                if (stop) begin
                    state_nxt     = HALTED;
                    ctr_clear     = 1'b1;
                    step_done_nxt = 1'b1;
                end else if (resume) begin
                    state_nxt = RUN;
                    ctr_clear = 1'b1;
                end else if (step_one) begin
                    state_nxt     = HALTED;
                    step_done_nxt = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    step_counter #(.CNT_W(CNT_W)) u_step_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .dec      (state == STEP),
        .clear    (ctr_clear),
        .load_val (step_n),
        .one      (step_one)
    );

    // Outputs decode the next state so they are flops, not gates off state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            run_en    <= 1'b1;
            halted    <= 1'b0;
            step_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            run_en    <= (state_nxt != HALTED);
            halted    <= (state_nxt == HALTED);
            step_done <= step_done_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (run_en && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

`ifdef RUN_CONTROL_CYCLE_LIMIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_hit <= 1'b0;
        end else if (limit_halt) begin
            limit_hit <= 1'b1;
        end else if (resume) begin
            limit_hit <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_run_control.sv
// Bench for run_control: directed pulses, a cycle-level behavioural model, literal pins.
// A second instance with a 4-bit counter exercises cycle_cnt saturation.
module tb_run_control;

`ifdef RUN_CONTROL_CYCLE_LIMIT_EN
    localparam bit LIM_ON = 1'b1;
`else
    localparam bit LIM_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  instr;
    logic        op_valid;
    logic        resume;
    logic        step_req;
    logic [15:0] step_n;
    logic [15:0] cyc_lim;
    logic        run_en, halted, step_done;
    logic [15:0] cycle_cnt;
    logic        run_en4, halted4, step_done4;
    logic [3:0]  cycle_cnt4;
`ifdef RUN_CONTROL_CYCLE_LIMIT_EN
    logic        limit_hit, limit_hit4;
`endif

    int checks = 0;
    int errors = 0;
    int cyc;

    run_control dut (
        .clk                  (clk),
        .rst                  (rst),
        .instruction_from_jno (instr),
        .op_valid             (op_valid),
        .resume               (resume),
        .step_req             (step_req),
        .step_n               (step_n),
`ifdef RUN_CONTROL_CYCLE_LIMIT_EN
        .cycle_limit          (cyc_lim),
        .limit_hit            (limit_hit),
`endif
        .run_en               (run_en),
        .halted               (halted),
        .step_done            (step_done),
        .cycle_cnt            (cycle_cnt)
    );

    run_control #(.CNT_W(4)) dut4 (
        .clk                  (clk),
        .rst                  (rst),
        .instruction_from_jno (2'b00),
        .op_valid             (1'b0),
        .resume               (1'b0),
        .step_req             (1'b0),
        .step_n               (4'd0),
`ifdef RUN_CONTROL_CYCLE_LIMIT_EN
        .cycle_limit          (4'd0),
        .limit_hit            (limit_hit4),
`endif
        .run_en               (run_en4),
        .halted               (halted4),
        .step_done            (step_done4),
        .cycle_cnt            (cycle_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Model: halted flag plus number of step cycles still owed (0 = free running).
    bit m_halted, m_run_en, m_done, m_lim;
    int m_steps, m_cnt, m4_cnt;

    always @(posedge clk or posedge rst) begin : model
        bit hm, lm, stp, h_n, d_n;
        int s_n;
        if (rst) begin
            m_halted <= 1'b0; m_run_en <= 1'b1; m_done <= 1'b0; m_lim <= 1'b0;
            m_steps  <= 0;    m_cnt    <= 0;    m4_cnt <= 0;
        end else begin
            hm  = op_valid && m_run_en && (instr == 2'b10);
            lm  = LIM_ON && m_run_en && (cyc_lim != 0) && (m_cnt == int'(cyc_lim) - 1);
            stp = hm || lm;
            h_n = m_halted; s_n = m_steps; d_n = 1'b0;
            if (m_halted) begin
                if (resume) h_n = 1'b0;
                else if (step_req && step_n != 0) begin h_n = 1'b0; s_n = int'(step_n); end
            end else if (m_steps == 0) begin
                if (stp) h_n = 1'b1;
            end else begin
                if (stp)               begin h_n = 1'b1; s_n = 0; d_n = 1'b1; end
                else if (resume)       s_n = 0;
                else if (m_steps == 1) begin h_n = 1'b1; s_n = 0; d_n = 1'b1; end
                else                   s_n = m_steps - 1;
            end
            m_halted <= h_n;
            m_run_en <= !h_n;
            m_steps  <= s_n;
            m_done   <= d_n;
            if (m_run_en) m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            m4_cnt   <= (m4_cnt >= 15) ? 15 : m4_cnt + 1;
            if (lm) m_lim <= 1'b1;
            else if (resume) m_lim <= 1'b0;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("model_run_en",    int'(run_en),     int'(m_run_en));
            check("model_halted",    int'(halted),     int'(m_halted));
            check("model_step_done", int'(step_done),  int'(m_done));
            check("model_cycle_cnt", int'(cycle_cnt),  m_cnt);
            check("model_cnt4",      int'(cycle_cnt4), m4_cnt);
`ifdef RUN_CONTROL_CYCLE_LIMIT_EN
            check("model_limit_hit", int'(limit_hit),  int'(m_lim));
`endif
        end
    end

    task automatic to_cycle(input int n);
        int guard = 0;
        if (cyc > n) begin
            errors++;
            $display("FAIL sequence cycle %0d already past %0d", cyc, n);
        end
        while (cyc < n && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic peek(input int n);
        to_cycle(n);
        @(negedge clk);
    endtask

    task automatic pulse(input int n, input bit vld, input logic [1:0] op,
                         input bit res, input bit sreq, input int sn);
        to_cycle(n);
        op_valid = vld; instr = op; resume = res; step_req = sreq; step_n = 16'(sn);
        to_cycle(n + 1);
        op_valid = 1'b0; instr = 2'b00; resume = 1'b0; step_req = 1'b0; step_n = 16'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr = 2'b00; op_valid = 1'b0; resume = 1'b0;
        step_req = 1'b0; step_n = 16'd0; cyc_lim = 16'd0;
        do_reset();

        peek(0);
        check("rst_run_en", int'(run_en), 1);
        check("rst_halted", int'(halted), 0);
        check("rst_cnt",    int'(cycle_cnt), 0);
        pulse(2, 1'b1, 2'b01, 1'b0, 1'b0, 0);
        pulse(3, 1'b0, 2'b00, 1'b1, 1'b1, 3);
        peek(5);
        check("pre_halt_run_en", int'(run_en), 1);
        pulse(5, 1'b1, 2'b10, 1'b0, 1'b0, 0);
        peek(6);
        check("halt_run_en", int'(run_en), 0);
        check("halt_halted", int'(halted), 1);
        check("halt_cnt",    int'(cycle_cnt), 6);
        pulse(8, 1'b1, 2'b10, 1'b0, 1'b0, 0);
        peek(9);
        check("op_while_halted", int'(halted), 1);
        pulse(10, 1'b0, 2'b00, 1'b1, 1'b0, 0);
        peek(11);
        check("resume_run_en", int'(run_en), 1);
        check("resume_cnt",    int'(cycle_cnt), 6);
        pulse(14, 1'b1, 2'b10, 1'b0, 1'b0, 0);
        pulse(20, 1'b0, 2'b00, 1'b0, 1'b1, 3);
        peek(23);
        check("step3_last_run_en", int'(run_en), 1);
        peek(24);
        check("step3_done",    int'(step_done), 1);
        check("step3_halted",  int'(halted), 1);
        check("step3_cnt",     int'(cycle_cnt), 13);
        peek(25);
        check("step3_done_clr", int'(step_done), 0);
        pulse(30, 1'b0, 2'b00, 1'b0, 1'b1, 5);
        pulse(32, 1'b1, 2'b10, 1'b0, 1'b0, 0);
        peek(33);
        check("step_hit_done", int'(step_done), 1);
        check("step_hit_cnt",  int'(cycle_cnt), 15);
        pulse(36, 1'b0, 2'b00, 1'b1, 1'b1, 4);
        check("res_step_run_en", int'(run_en), 1);
        peek(42);
        check("res_step_no_step", int'(run_en), 1);
        pulse(44, 1'b1, 2'b10, 1'b0, 1'b0, 0);
        pulse(47, 1'b0, 2'b00, 1'b0, 1'b1, 0);
        peek(49);
        check("step0_halted", int'(halted), 1);
        check("step0_cnt",    int'(cycle_cnt), 23);
        pulse(50, 1'b0, 2'b00, 1'b0, 1'b1, 6);
        pulse(52, 1'b0, 2'b00, 1'b1, 1'b0, 0);
        peek(53);
        check("step_res_run_en", int'(run_en), 1);
        check("step_res_done",   int'(step_done), 0);
        pulse(55, 1'b0, 2'b00, 1'b0, 1'b1, 2);
        peek(60);
        check("run_ignores_step", int'(run_en), 1);
        pulse(62, 1'b1, 2'b10, 1'b0, 1'b0, 0);
        peek(63);
        check("halt2_cnt", int'(cycle_cnt), 35);
        pulse(65, 1'b0, 2'b00, 1'b0, 1'b1, 4);
        pulse(67, 1'b1, 2'b10, 1'b1, 1'b0, 0);
        peek(68);
        check("hit_beats_resume", int'(halted), 1);
        check("hit_res_done",     int'(step_done), 1);
        check("hit_res_cnt",      int'(cycle_cnt), 37);
        pulse(70, 1'b0, 2'b00, 1'b0, 1'b1, 8);
        peek(73);
        check("mid_step_cnt", int'(cycle_cnt), 39);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cnt",    int'(cycle_cnt), 0);
        check("async_rst_run_en", int'(run_en), 1);
        check("async_rst_done",   int'(step_done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        pulse(5, 1'b0, 2'b00, 1'b0, 1'b1, 2);
        peek(20);
        check("post_rst_run_en", int'(run_en), 1);
        check("post_rst_cnt",    int'(cycle_cnt), 20);
        check("sat_cnt4",        int'(cycle_cnt4), 15);

`ifdef RUN_CONTROL_CYCLE_LIMIT_EN
        cyc_lim = 16'd4;
        do_reset();
        peek(3);
        check("lim_run_en3", int'(run_en), 1);
        peek(4);
        check("lim_halted",  int'(halted), 1);
        check("lim_hit",     int'(limit_hit), 1);
        check("lim_cnt",     int'(cycle_cnt), 4);
        pulse(7, 1'b0, 2'b00, 1'b1, 1'b0, 0);
        check("lim_cleared", int'(limit_hit), 0);
        check("lim_resume",  int'(run_en), 1);
        peek(10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
